// File: rtl/byte_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_fill_pkg
// Description : Shared definitions for the byte stream filler. It holds the
//               filler state encoding and the default fill byte.
// Revision    : 1.0 - initial release
// ============================================================================
package byte_fill_pkg;

    // Filler FSM states. FILL is the reset state.
    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } fill_state_t;

    // Byte emitted whenever no real data is being streamed.
    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Byte FIFO with a DEPTH-entry store, wrapping read and write
//               pointers, and an occupancy count. The head is read
//               combinationally from storage and has no output register.
// Ports       : clk, rst (async, active-high)
//               push, push_data  - write one byte at the tail
//               pop              - retire the head entry
//               head             - current head byte (valid when count != 0)
//               count            - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    // Guard against overflow and underflow locally, so the storage stays
    // consistent even if a caller requests an illegal operation.
    assign w_push = push && (r_count != DEPTH_C);
    assign w_pop  = pop  && (r_count != '0);

    // Storage has no reset. Entries are only observed after they are
    // written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/byte_stream_filler.sv
`default_nettype none
// ============================================================================
// Module      : byte_stream_filler
// Description : Accepts bursty bytes over a valid/ready handshake and emits a
//               gap-free registered byte stream, one byte per clock. IDLE_BYTE
//               is inserted whenever no data is available. Streaming starts
//               only once START_THRESH bytes have accumulated, which acts as
//               a jitter buffer.
// Ports       : clk, rst (async, active-high)
//               in_data/in_valid/in_ready - input handshake
//               out_data, out_is_idle     - registered output stream
//               count                     - FIFO occupancy
//               underrun                  - 1-cycle pulse when STREAM ran dry
//               idle_count                - (BYTE_FILL_STATS_EN only)
//                                           saturating count of idle bytes
// Config      : define BYTE_FILL_STATS_EN to add the idle_count statistic.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_stream_filler
    import byte_fill_pkg::*;
#(
    parameter int         DEPTH        = 8,
    parameter int         START_THRESH = 4,
    parameter logic [7:0] IDLE_BYTE    = DEFAULT_IDLE_BYTE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_is_idle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underrun
`ifdef BYTE_FILL_STATS_EN
    ,
    output logic [15:0]              idle_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(START_THRESH);

    fill_state_t   r_state;
    logic [7:0]    r_out_data;
    logic          r_out_is_idle;
    logic          r_underrun;

    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic          w_push;
    logic          w_pop;

    // in_ready depends on the registered count only. A pop on the same edge
    // never opens a slot early.
    assign in_ready = (w_count < DEPTH_C);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == ST_STREAM) && (w_count != '0);

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    // The threshold test uses the count from before this edge's push, so the
    // first real byte appears one edge after the threshold is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_FILL;
            r_out_data    <= IDLE_BYTE;
            r_out_is_idle <= 1'b1;
            r_underrun    <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    r_out_data    <= IDLE_BYTE;
                    r_out_is_idle <= 1'b1;
                    r_underrun    <= 1'b0;
                    if (w_count >= THRESH_C) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_pop) begin
                        r_out_data    <= w_head;
                        r_out_is_idle <= 1'b0;
                        r_underrun    <= 1'b0;
                    end else begin
                        r_out_data    <= IDLE_BYTE;
                        r_out_is_idle <= 1'b1;
                        r_underrun    <= 1'b1;
                        r_state       <= ST_FILL;
                    end
                end
                default: begin
                    r_state       <= ST_FILL;
                    r_out_data    <= IDLE_BYTE;
                    r_out_is_idle <= 1'b1;
                    r_underrun    <= 1'b0;
                end
            endcase
        end
    end

`ifdef BYTE_FILL_STATS_EN
    logic [15:0] r_idle_count;

    // An idle byte is driven on every edge that does not pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_count <= '0;
        end else if (!w_pop && (r_idle_count != 16'hFFFF)) begin
            r_idle_count <= r_idle_count + 16'd1;
        end
    end

    assign idle_count = r_idle_count;
`endif

    assign out_data    = r_out_data;
    assign out_is_idle = r_out_is_idle;
    assign count       = w_count;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: doc/byte_stream_filler.md
# byte_stream_filler

Upstream feeder for the 8-bit ring-buffer capture stage, which consumes exactly one byte on every clock. This block accepts bursty bytes over a valid/ready handshake and buffers them in a small FIFO. It emits a gap-free byte stream, one byte per cycle, inserting a fixed idle byte whenever no data is available. A start threshold acts as a jitter buffer: bytes are not released until enough have accumulated.

## Interface
- DEPTH, 8: FIFO entries; power of two, 4..64.
- START_THRESH, 4: occupancy needed to begin streaming; 1..DEPTH.
- IDLE_BYTE, 8'h00: byte emitted when not streaming.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  8  input byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept; high when count < DEPTH.
- out_data  out  8  registered byte stream to ring buffer (data_in), new value every cycle.
- out_is_idle  out  1  out_data is a fill byte.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- underrun  out  1  one-cycle pulse when STREAM runs dry.

## Operation
- A push occurs on an edge where in_valid && in_ready. in_ready is combinational from count only; it is never raised by a same-cycle pop.
- FSM with two states:
  - FILL (reset state): out_data <= IDLE_BYTE, out_is_idle <= 1, no pop. Go to STREAM when count >= START_THRESH, with count evaluated before this edge's push.
  - STREAM: if count != 0, pop the head into out_data and set out_is_idle <= 0. If count == 0, emit IDLE_BYTE, set out_is_idle <= 1, pulse underrun, and go to FILL.
- Push and pop on the same edge: count is unchanged and both operations complete.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. A push when count == DEPTH cannot occur because in_ready is low.
- Reset mid-operation drops all buffered bytes with no flush.
- Reset values: out_data = IDLE_BYTE, out_is_idle = 1, count = 0, underrun = 0, state = FILL, in_ready = 1.

## Timing
- A byte pushed at edge N is visible in the FIFO (count) after edge N.
- In STREAM, that byte appears on out_data after edge N+1 at the earliest, so minimum latency is 1 cycle after acceptance.
- FILL→STREAM: the first real byte appears on out_data after the edge following the edge at which the threshold was met.
- underrun is high for exactly the cycle after the edge at which the empty FIFO was detected in STREAM.
- out_data changes only on clk edges; there is no combinational path from in_* to out_*.

## Configuration
- BYTE_FILL_STATS_EN defined: adds output idle_count (16 bits), which increments on every edge where out_is_idle is driven to 1. It saturates at 16'hFFFF and resets to 0.
- BYTE_FILL_STATS_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package byte_fill_pkg holds the state enum (FILL, STREAM) and the default IDLE_BYTE constant.
- Sub-module byte_fifo holds storage, read/write pointers and count. It exposes push, pop, head and count, with no output register. Top level contains the FSM and the output registers.

## Test plan
- Reset, no input for 20 cycles → out_data = 8'h00, out_is_idle = 1 every cycle, underrun never asserted.
- Push 8'h11,22,33,44 back-to-back (START_THRESH = 4) → FILL until the 4th push. out_data then yields 11,22,33,44 on consecutive cycles, followed by one IDLE byte with underrun = 1, and the FSM returns to FILL.
- Continuous in_valid with one byte per cycle after the threshold → count holds steady and out_data is an unbroken ascending sequence with no idle bytes.
- Push 8 bytes while in FILL (START_THRESH = DEPTH = 8) → in_ready falls at count = 8, a 9th byte held on in_valid is not accepted, and all 8 bytes drain in order.
- Assert rst in the middle of STREAM with count = 3 → outputs return to reset values immediately and the 3 buffered bytes are never emitted.
- With BYTE_FILL_STATS_EN defined: 10 idle cycles after reset → idle_count = 10. A forced long idle period → idle_count saturates at 16'hFFFF.
